// File: rtl/modn_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modn_counter_ctrl_pkg
//  Description : Shared FSM state codes and widths for the modulo-N
//                run/stop/step/load counter controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package modn_counter_ctrl_pkg;

    localparam int unsigned c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/modn_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : modn_counter_ctrl_if
//  Description : Front-panel command / counter status bundle. The master
//                side drives button levels and configuration, the slave side
//                (the controller) returns count, terminal count and state.
//  Revision    : 1.0 - initial release
// ============================================================================
interface modn_counter_ctrl_if #(
    parameter int WIDTH = 3
);
    import modn_counter_ctrl_pkg::*;

    logic                 start;
    logic                 stop;
    logic                 step;
    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic [WIDTH:0]       mod_val;
    logic                 up;
    logic [WIDTH-1:0]     q;
    logic                 tc;
    logic                 running;
    logic [c_STATE_W-1:0] state;

    modport master (
        output start, stop, step, load, load_val, mod_val, up,
        input  q, tc, running, state
    );

    modport slave (
        input  start, stop, step, load, load_val, mod_val, up,
        output q, tc, running, state
    );

endinterface
`default_nettype wire

// File: rtl/modn_counter_ctrl_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Single-bit rising-edge detector. Emits a combinational
//                one-cycle pulse in the cycle the input is first seen high.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  wire logic clk,
    input  wire logic clr,
    input  wire logic in,
    output logic      pulse
);

    logic r_prev;

    // Remember last sampled level; cleared so a level held through reset fires.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign pulse = in & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/modn_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : modn_counter_ctrl
//  Description : Run/stop/step/load controller around a programmable
//                modulo-N up/down counter with a registered terminal-count
//                pulse for cascading.
//  Revision    : 1.0 - initial release
// ============================================================================
module modn_counter_ctrl
    import modn_counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int DEFAULT_MOD = 6
) (
    input  wire logic          clk,
    input  wire logic          clr,
    modn_counter_ctrl_if.slave bus
);

    localparam logic [WIDTH:0]   c_MOD_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   c_MOD_MIN = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]   c_MOD_DEF = (WIDTH+1)'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    // Command pulses: bit 0 start, 1 stop, 2 step, 3 load
    logic [3:0] w_cmd_lvl;
    logic [3:0] w_cmd_pls;
    logic       w_start_p;
    logic       w_stop_p;
    logic       w_step_p;
    logic       w_load_p;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_running;
    logic             w_adv;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    logic [WIDTH:0]   w_meff;
    logic [WIDTH:0]   w_top_ext;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH:0]   w_q_ext;

    assign w_cmd_lvl = {bus.load, bus.step, bus.stop, bus.start};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rise
            rise_detect u_rise (
                .clk   (clk),
                .clr   (clr),
                .in    (w_cmd_lvl[gi]),
                .pulse (w_cmd_pls[gi])
            );
        end
    endgenerate

    assign w_start_p = w_cmd_pls[0];
    assign w_stop_p  = w_cmd_pls[1];
    assign w_step_p  = w_cmd_pls[2];
    assign w_load_p  = w_cmd_pls[3];

    // Out-of-range moduli fall back to the build-time default.
    assign w_meff    = ((bus.mod_val >= c_MOD_MIN) && (bus.mod_val <= c_MOD_MAX))
                     ? bus.mod_val : c_MOD_DEF;
    assign w_top_ext = w_meff - (WIDTH+1)'(1);
    assign w_top     = w_top_ext[WIDTH-1:0];
    assign w_q_ext   = {1'b0, r_q};

    // Next state and advance enable; stop outranks start on a shared edge.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_adv = w_step_p;
                if (!w_stop_p && w_start_p) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_adv = ~w_stop_p;
                if (w_stop_p) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_adv = w_step_p;
                if (!w_stop_p && w_start_p) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter next value: load beats advance; out-of-range q snaps without tc.
    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (w_load_p) begin
            w_q_nxt = ({1'b0, bus.load_val} >= w_meff) ? '0 : bus.load_val;
        end else if (w_adv) begin
            if (bus.up) begin
                if (w_q_ext == w_top_ext) begin
                    w_q_nxt  = '0;
                    w_tc_nxt = 1'b1;
                end else if (w_q_ext > w_top_ext) begin
                    w_q_nxt  = '0;
                end else begin
                    w_q_nxt  = r_q + c_ONE;
                end
            end else begin
                if (r_q == '0) begin
                    w_q_nxt  = w_top;
                    w_tc_nxt = 1'b1;
                end else if (w_q_ext > w_top_ext) begin
                    w_q_nxt  = w_top;
                end else begin
                    w_q_nxt  = r_q - c_ONE;
                end
            end
        end
    end

    // State register with running flag registered alongside it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.tc      = r_tc;
    assign bus.running = r_running;
    assign bus.state   = r_state;

endmodule
`default_nettype wire
